// File: rtl/skew_fifo_bank.sv
// Bank of per-channel circular FIFOs feeding a systolic array. Channel k output passes a
// read register plus k skew stages, so one lockstep pop leaves the bank as a diagonal wavefront.
module skew_fifo_bank #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        wr_en,
  input  logic [NCH*DATA_W-1:0] din,
  input  logic                  rd_en,
  input  logic                  mode,
  input  logic                  clr_err,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        empty,
  output logic [NCH*CW-1:0]     level,
  output logic [NCH*DATA_W-1:0] dout,
  output logic [NCH-1:0]        dout_valid,
  output logic [NCH-1:0]        ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [NCH-1:0] pop;
  logic           pop_all;

  // Lockstep pops only when every channel can supply an entry.
  always_comb begin
    pop_all = rd_en && (empty == '0);
    pop     = '0;
    for (int k = 0; k < NCH; k++) begin
      pop[k] = mode ? (rd_en && !empty[k]) : pop_all;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int unsigned NS = g + 1;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]        wptr_q;
    logic [AW-1:0]        rptr_q;
    logic [CW-1:0]        cnt_q;
    logic                 ovf_q;
    logic [NS-1:0]        pv_q;
    logic [NS*DATA_W-1:0] pd_q;
    logic                 push;
    logic                 drop;
    logic [DATA_W-1:0]    rd_word;

    assign full[g]  = (cnt_q == CW'(DEPTH));
    assign empty[g] = (cnt_q == '0);
    assign push     = wr_en[g] && !full[g];
    assign drop     = wr_en[g] && full[g];
    assign rd_word  = pop[g] ? mem_q[rptr_q] : '0;

    assign level[g*CW +: CW]         = cnt_q;
    assign ovf[g]                    = ovf_q;
    assign dout_valid[g]             = pv_q[NS-1];
    assign dout[g*DATA_W +: DATA_W]  = pd_q[NS*DATA_W-1 -: DATA_W];

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wptr_q] <= din[g*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        pv_q   <= '0;
        pd_q   <= '0;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + AW'(1);
        end
        if (pop[g]) begin
          rptr_q <= rptr_q + AW'(1);
        end
        unique case ({push, pop[g]})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
        // A fresh drop wins over a simultaneous clear.
        ovf_q <= drop || (ovf_q && !clr_err);
        // Newest entry enters at the low end; the top slot drives dout.
        pv_q  <= NS'({pv_q, pop[g]});
        pd_q  <= (NS*DATA_W)'({pd_q, rd_word});
      end
    end
  end

endmodule
